// File: rtl/mem_write_monitor.sv
// Passive data-memory store observer: logs stores into an FWFT FIFO,
// counts them and decides pass / fail / timeout for the simulation top.
module mem_write_monitor #(
    parameter int          DEPTH          = 16,
    parameter logic [31:0] DONE_ADDR      = 32'd100,
    parameter logic [31:0] PASS_VALUE     = 32'd7,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_write,
    input  logic [31:0]              data_adr,
    input  logic [31:0]              write_data,
    input  logic [31:0]              pc,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [31:0]              rd_addr,
    output logic [31:0]              rd_data,
    output logic [31:0]              rd_pc,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [15:0]              write_count,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     idle_q, idle_d;
    logic [15:0]     wcnt_q, wcnt_d;
    logic            ovf_q, ovf_d;
    logic            pass_q, fail_q, timeout_q, done_q;

    logic [31:0]     addr_mem [DEPTH];
    logic [31:0]     data_mem [DEPTH];
    logic [31:0]     pc_mem   [DEPTH];

    logic store, pop, full, push, drop;

    assign store = (state_q == S_RUN) && mem_write;
    assign pop   = rd_en && (count_q != '0);
    assign full  = (count_q == CW'(DEPTH));
    // A full log still accepts a store when the head leaves on the same edge.
    assign push  = store && (!full || pop);
    assign drop  = store && full && !pop;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wcnt_d  = wcnt_q;
        ovf_d   = ovf_q | drop;
        count_d = count_q + CW'(push) - CW'(pop);
        if (state_q == S_RUN) begin
            if (mem_write) begin
                idle_d = '0;
                if (wcnt_q != 16'hFFFF)
                    wcnt_d = wcnt_q + 16'd1;
                if (data_adr == DONE_ADDR)
                    state_d = (write_data == PASS_VALUE) ? S_PASS : S_FAIL;
            end else if (TIMEOUT_CYCLES != 0) begin
                idle_d = idle_q + 32'd1;
                if (idle_q == TO_LAST)
                    state_d = S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            idle_q    <= '0;
            wcnt_q    <= '0;
            ovf_q     <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idle_q    <= idle_d;
            wcnt_q    <= wcnt_d;
            ovf_q     <= ovf_d;
            pass_q    <= (state_d == S_PASS);
            fail_q    <= (state_d == S_FAIL);
            timeout_q <= (state_d == S_TIMEOUT);
            done_q    <= (state_d != S_RUN);
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= data_adr;
            data_mem[wr_ptr_q] <= write_data;
            pc_mem[wr_ptr_q]   <= pc;
        end
    end

    // Storage is not reset, so the head fields read zero while empty.
    assign rd_valid    = (count_q != '0);
    assign rd_addr     = rd_valid ? addr_mem[rd_ptr_q] : 32'd0;
    assign rd_data     = rd_valid ? data_mem[rd_ptr_q] : 32'd0;
    assign rd_pc       = rd_valid ? pc_mem[rd_ptr_q]   : 32'd0;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;
    assign write_count = wcnt_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: logging, verdicts, overflow,
// timeout and asynchronous reset behaviour.
module tb_mem_write_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mw_b, mw_c;
    logic [31:0] data_adr, write_data, pc;
    logic        rd_en;

    logic        rd_valid, ovf, done, pass, fail, timeout;
    logic [31:0] rd_addr, rd_data, rd_pc;
    logic [4:0]  fifo_count;
    logic [15:0] write_count;

    logic        b_valid, b_ovf, b_done, b_pass, b_fail, b_to;
    logic [31:0] b_addr, b_data, b_pc;
    logic [4:0]  b_cnt;
    logic [15:0] b_wc;

    logic        c_valid, c_ovf, c_done, c_pass, c_fail, c_to;
    logic [31:0] c_addr, c_data, c_pc;
    logic [4:0]  c_cnt;
    logic [15:0] c_wc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_write_monitor dut (
        .clk(clk), .reset(reset), .mem_write(mem_write),
        .data_adr(data_adr), .write_data(write_data), .pc(pc),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_pc(rd_pc), .fifo_count(fifo_count),
        .overflow(ovf), .write_count(write_count), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout)
    );

    mem_write_monitor #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset), .mem_write(mw_b),
        .data_adr(data_adr), .write_data(write_data), .pc(pc),
        .rd_en(1'b0), .rd_valid(b_valid), .rd_addr(b_addr),
        .rd_data(b_data), .rd_pc(b_pc), .fifo_count(b_cnt),
        .overflow(b_ovf), .write_count(b_wc), .done(b_done),
        .pass(b_pass), .fail(b_fail), .timeout(b_to)
    );

    mem_write_monitor #(.TIMEOUT_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .mem_write(mw_c),
        .data_adr(data_adr), .write_data(write_data), .pc(pc),
        .rd_en(1'b0), .rd_valid(c_valid), .rd_addr(c_addr),
        .rd_data(c_data), .rd_pc(c_pc), .fifo_count(c_cnt),
        .overflow(c_ovf), .write_count(c_wc), .done(c_done),
        .pass(c_pass), .fail(c_fail), .timeout(c_to)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_write = 0; mw_b = 0; mw_c = 0; rd_en = 0;
        data_adr = 32'h300; write_data = 0; pc = 0;
        reset = 0;
        cyc(); cyc();
        reset = 1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic re);
        mem_write = 1; data_adr = a; write_data = d; pc = p; rd_en = re;
        cyc();
        mem_write = 0; rd_en = 0; data_adr = 32'h300;
    endtask

    task automatic pop1();
        rd_en = 1;
        cyc();
        rd_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({rd_valid, fifo_count, ovf, write_count} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_fifo: got v=%b c=%0d o=%b wc=%0d want 0",
                     rd_valid, fifo_count, ovf, write_count);
        end
        n_tests++;
        if ({rd_addr, rd_data, rd_pc} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_head: got %h/%h/%h want 0", rd_addr, rd_data, rd_pc);
        end
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {done, pass, fail, timeout});
        end
    endtask

    task automatic test_stores();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        logic [31:0] ep [3];
        ea = '{32'h40, 32'h44, 32'h48};
        ed = '{32'h11, 32'h22, 32'h33};
        ep = '{32'h8, 32'hC, 32'h10};
        do_reset();
        for (int i = 0; i < 3; i++) store(ea[i], ed[i], ep[i], 1'b0);
        n_tests++;
        if (fifo_count !== 5'd3 || write_count !== 16'd3) begin
            n_fail++;
            $display("FAIL store_counts: got c=%0d wc=%0d want 3/3", fifo_count, write_count);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (rd_valid !== 1'b1 || rd_addr !== ea[i] || rd_data !== ed[i] || rd_pc !== ep[i]) begin
                n_fail++;
                $display("FAIL head_%0d: got v=%b %h/%h/%h want 1 %h/%h/%h",
                         i, rd_valid, rd_addr, rd_data, rd_pc, ea[i], ed[i], ep[i]);
            end
            pop1();
        end
        n_tests++;
        if (rd_valid !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL drained: got v=%b c=%0d want 0/0", rd_valid, fifo_count);
        end
        pop1();
        n_tests++;
        if (fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL pop_empty: got c=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_pass_fail();
        do_reset();
        store(32'd100, 32'd7, 32'h20, 1'b0);
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b1100) begin
            n_fail++;
            $display("FAIL pass_flags: got %b want 1100", {done, pass, fail, timeout});
        end
        store(32'h60, 32'h5, 32'h24, 1'b0);
        n_tests++;
        if (write_count !== 16'd1 || fifo_count !== 5'd1 || rd_addr !== 32'd100) begin
            n_fail++;
            $display("FAIL post_pass: got wc=%0d c=%0d a=%h want 1/1/64",
                     write_count, fifo_count, rd_addr);
        end
        // Clear mid-cycle with no clock edge
        @(posedge clk);
        #3;
        reset = 0;
        #1;
        n_tests++;
        if (fifo_count !== 5'd0 || {done, pass, fail, timeout} !== 4'b0 ||
            write_count !== 16'd0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got c=%0d f=%b wc=%0d v=%b want 0",
                     fifo_count, {done, pass, fail, timeout}, write_count, rd_valid);
        end
        do_reset();
        store(32'd100, 32'd5, 32'h20, 1'b0);
        n_tests++;
        if ({done, pass, fail, timeout} !== 4'b1010) begin
            n_fail++;
            $display("FAIL fail_flags: got %b want 1010", {done, pass, fail, timeout});
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) store(32'(i * 4), 32'(i), 32'(i + 1000), 1'b0);
        n_tests++;
        if (fifo_count !== 5'd16 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL fill16: got c=%0d o=%b want 16/0", fifo_count, ovf);
        end
        store(32'h200, 32'hAA, 32'h0, 1'b0);
        n_tests++;
        if (fifo_count !== 5'd16 || ovf !== 1'b1 || write_count !== 16'd17) begin
            n_fail++;
            $display("FAIL overflow: got c=%0d o=%b wc=%0d want 16/1/17",
                     fifo_count, ovf, write_count);
        end
        n_tests++;
        if (rd_addr !== 32'h0 || rd_pc !== 32'd1000) begin
            n_fail++;
            $display("FAIL ovf_head: got %h/%h want 0/3e8", rd_addr, rd_pc);
        end
        for (int i = 0; i < 15; i++) pop1();
        n_tests++;
        if (rd_addr !== 32'd60 || fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL ovf_tail: got a=%h c=%0d want 3c/1", rd_addr, fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) store(32'(i * 4), 32'(i), 32'(i), 1'b0);
        store(32'h200, 32'hBB, 32'h44, 1'b1);
        n_tests++;
        if (fifo_count !== 5'd16 || ovf !== 1'b0 || rd_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL full_pushpop: got c=%0d o=%b a=%h want 16/0/4",
                     fifo_count, ovf, rd_addr);
        end
        for (int i = 0; i < 15; i++) pop1();
        n_tests++;
        if (rd_addr !== 32'h200 || rd_data !== 32'hBB || rd_pc !== 32'h44 || fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL wrap_entry: got %h/%h/%h c=%0d want 200/bb/44 1",
                     rd_addr, rd_data, rd_pc, fifo_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 7; i++) cyc();
        n_tests++;
        if (b_to !== 1'b0 || b_done !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got t=%b d=%b want 0/0", b_to, b_done);
        end
        cyc();
        n_tests++;
        if ({b_done, b_pass, b_fail, b_to} !== 4'b1001) begin
            n_fail++;
            $display("FAIL to_fire: got %b want 1001", {b_done, b_pass, b_fail, b_to});
        end
        do_reset();
        for (int i = 0; i < 6; i++) cyc();
        mw_b = 1;
        cyc();
        mw_b = 0;
        for (int i = 0; i < 7; i++) cyc();
        n_tests++;
        if (b_to !== 1'b0 || b_wc !== 16'd1) begin
            n_fail++;
            $display("FAIL to_rearm: got t=%b wc=%0d want 0/1", b_to, b_wc);
        end
        cyc();
        n_tests++;
        if (b_to !== 1'b1) begin
            n_fail++;
            $display("FAIL to_after_store: got %b want 1", b_to);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        for (int i = 0; i < 2000; i++) cyc();
        n_tests++;
        if (c_to !== 1'b0 || c_done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout: got t=%b d=%b want 0/0", c_to, c_done);
        end
        mw_c = 1; data_adr = 32'd100; write_data = 32'd7;
        cyc();
        mw_c = 0; data_adr = 32'h300;
        n_tests++;
        if (c_pass !== 1'b1 || c_wc !== 16'd1) begin
            n_fail++;
            $display("FAIL still_run: got p=%b wc=%0d want 1/1", c_pass, c_wc);
        end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_pass_fail();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_no_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
Passive observer on the processor data-memory write port: it is the read side of the core's store stream. It captures every store (address, data, PC) into a first-word-fall-through (FWFT) log FIFO and counts stores. It decides test completion: PASS or FAIL from a store to a sentinel address, or TIMEOUT after a long run of cycles with no stores. Sits in the simulation top beside dmem, wired to MemWrite/DataAdr/WriteData/PC; never drives the bus.

Parameters:
DEPTH, 16, log FIFO entries (power of two, >=2)
DONE_ADDR, 32'd100, sentinel store address that ends the test
PASS_VALUE, 32'd7, store data at DONE_ADDR meaning pass
TIMEOUT_CYCLES, 1024, consecutive store-free cycles before timeout; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_write  input  1  processor store strobe
data_adr  input  32  store address
write_data  input  32  store data
pc  input  32  PC of the storing instruction
rd_en  input  1  pop request for log head
rd_valid  output  1  log non-empty; rd_* fields valid
rd_addr  output  32  head entry address
rd_data  output  32  head entry data
rd_pc  output  32  head entry PC
fifo_count  output  $clog2(DEPTH)+1  entries held
overflow  output  1  sticky: a store was dropped because the log was full
write_count  output  16  stores observed in RUN, saturating
done  output  1  pass | fail | timeout
pass  output  1  sticky pass flag
fail  output  1  sticky fail flag
timeout  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, FIFO empty, fifo_count=0, rd_valid=0, rd_addr/rd_data/rd_pc=0, overflow=0, write_count=0, idle counter=0, all flags 0. Reset asserted mid-operation clears everything immediately, with no clock needed.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and held until reset.
- RUN, rising edge with mem_write=1:
  - Push {data_adr, write_data, pc} into the log.
  - write_count increments, saturating at 16'hFFFF.
  - Idle counter clears to 0.
  - If data_adr==DONE_ADDR: next state is PASS when write_data==PASS_VALUE, otherwise FAIL.
  - The sentinel store is itself logged and counted.
- RUN, rising edge with mem_write=0:
  - Idle counter increments.
  - If TIMEOUT_CYCLES!=0 and the counter already equals TIMEOUT_CYCLES-1, next state is TIMEOUT.
  - Result: timeout rises after exactly TIMEOUT_CYCLES consecutive store-free edges.
- Terminal states: stores are ignored. No push, no count change, no overflow update. Log readout continues normally.
- Flags are registered. pass/fail/timeout/done go high on the edge after the deciding store or idle cycle and are mutually exclusive.
- FIFO (FWFT):
  - rd_valid = (fifo_count != 0).
  - rd_* always show the oldest entry. An entry pushed into an empty FIFO is visible the cycle after the capture edge.
  - rd_en && rd_valid pops on the edge. rd_en while empty is ignored.
  - Push only (not full): count+1.
  - Push while full with no pop: entry dropped, overflow set (sticky), count stays DEPTH, write_count still increments.
  - Push and pop on the same edge: count unchanged, including when full (no overflow).
  - Pointers wrap modulo DEPTH.
- Outputs are purely registered. No combinational path from mem_write/data_adr to any output.

Test Plan:
- Reset: hold reset=0 then release -> all outputs 0, rd_valid=0. Assert reset=0 mid-test with no clock edge -> fifo_count=0, flags=0 immediately.
- Stores (0x40,0x11,pc 0x8), (0x44,0x22,pc 0xC), (0x48,0x33,pc 0x10) -> fifo_count=3, write_count=3. Head reads 0x40/0x11/0x8. Three rd_en pops return entries in order, then rd_valid=0.
- Store (100,7) -> pass=1, done=1 the next cycle. A subsequent store (0x60,0x5) leaves write_count=1 and fifo_count=1. A separate run with store (100,5) -> fail=1, pass=0.
- 16 stores with no pops -> fifo_count=16, overflow=0. 17th store -> overflow=1, fifo_count=16, write_count=17. After reset, fill to 16, then store with rd_en=1 on the same edge -> fifo_count=16, overflow=0.
- TIMEOUT_CYCLES=8, no stores -> timeout=1 after the 8th idle edge. A store on the 7th idle cycle -> no timeout until 8 further idle edges.
- TIMEOUT_CYCLES=0, 2000 idle cycles -> timeout stays 0, state remains RUN.
